// File: rtl/dcache_wb_2way.sv
// Two-way set-associative, write-back, write-allocate data cache for the MEM stage.
// Misses evict through WRITEBACK (dirty victim only) then REFILL over a line-wide memory port.
module dcache_wb_2way #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WORD_SIZE-1:0]             A,
  input  logic                             ReadEnable,
  input  logic                             WriteEnable,
  input  logic                             WriteByte,
  input  logic [WORD_SIZE-1:0]             WData,
  output logic [WORD_SIZE-1:0]             Value,
  output logic                             CacheStall,
  output logic [WORD_SIZE-1:0]             AMem,
  output logic                             MemRead,
  output logic                             MemWrite,
  output logic [LINE_WORDS*WORD_SIZE-1:0]  MemWLine,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]  MemLine,
  input  logic                             MemReady,
  output logic [1:0]                       o_dbg_state
);
  localparam int OB = $clog2(LINE_WORDS * WORD_SIZE / 8);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TW = WORD_SIZE - OB - IB;
  localparam int WB = $clog2(LINE_WORDS);
  localparam int LW = LINE_WORDS * WORD_SIZE;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITEBACK = 2'd1, S_REFILL = 2'd2} state_t;

  state_t              r_state, w_next;
  logic [TW-1:0]       r_tag   [2][NUM_SETS];
  logic [LW-1:0]       r_data  [2][NUM_SETS];
  logic [NUM_SETS-1:0] r_valid [2];
  logic [NUM_SETS-1:0] r_dirty [2];
  logic [NUM_SETS-1:0] r_lru;
  logic                r_vway;
  logic [WORD_SIZE-1:0] r_value;

  logic [TW-1:0]        w_tag;
  logic [IB-1:0]        w_idx;
  logic [WB-1:0]        w_wsel;
  logic [1:0]           w_bsel;
  logic                 w_req, w_hit0, w_hit1, w_hit, w_hway, w_vway;
  logic [LW-1:0]        w_line, w_new_line;
  logic [WORD_SIZE-1:0] w_word, w_new_word;

  assign w_tag  = A[WORD_SIZE-1 -: TW];
  assign w_idx  = A[OB +: IB];
  assign w_wsel = A[2 +: WB];
  assign w_bsel = A[1:0];
  assign w_req  = ReadEnable | WriteEnable;
  assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  assign w_hway = w_hit1;
  assign w_line = r_data[w_hway][w_idx];
  assign w_word = w_line[int'(w_wsel)*WORD_SIZE +: WORD_SIZE];

  // Fill an invalid way first (way0 before way1); otherwise evict the LRU way.
  assign w_vway = !r_valid[0][w_idx] ? 1'b0 :
                  !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

  always_comb begin
    w_new_word = WData;
    if (WriteByte) begin
      w_new_word = w_word;
      w_new_word[int'(w_bsel)*8 +: 8] = WData[7:0];
    end
    w_new_line = w_line;
    w_new_line[int'(w_wsel)*WORD_SIZE +: WORD_SIZE] = w_new_word;
  end

  always_comb begin
    w_next     = r_state;
    CacheStall = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AMem       = '0;
    MemWLine   = '0;
    Value      = r_value;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_hit) begin
          Value = w_word;
        end else if (w_req) begin
          CacheStall = 1'b1;
          if (r_valid[w_vway][w_idx] && r_dirty[w_vway][w_idx]) w_next = S_WRITEBACK;
          else                                                  w_next = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        CacheStall = 1'b1;
        MemWrite   = 1'b1;
        AMem       = {r_tag[r_vway][w_idx], w_idx, {OB{1'b0}}};
        MemWLine   = r_data[r_vway][w_idx];
        if (MemReady) w_next = S_REFILL;
      end
      S_REFILL: begin
        CacheStall = 1'b1;
        MemRead    = 1'b1;
        AMem       = {w_tag, w_idx, {OB{1'b0}}};
        if (MemReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Line data is not reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru    <= '0;
      r_vway   <= 1'b0;
      r_value  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req && w_hit) begin
            r_value      <= w_word;
            r_lru[w_idx] <= ~w_hway;
            if (WriteEnable) begin
              r_data[w_hway][w_idx]  <= w_new_line;
              r_dirty[w_hway][w_idx] <= 1'b1;
            end
          end else if (w_req) begin
            r_vway <= w_vway;
          end
        end
        S_WRITEBACK: begin
          if (MemReady) r_dirty[r_vway][w_idx] <= 1'b0;
        end
        S_REFILL: begin
          if (MemReady) begin
            r_data[r_vway][w_idx]  <= MemLine;
            r_tag[r_vway][w_idx]   <= w_tag;
            r_valid[r_vway][w_idx] <= 1'b1;
            r_dirty[r_vway][w_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dbg_state = r_state;
endmodule

// File: doc/dcache_wb_2way.md
Name: dcache_wb_2way

Overview:
- Parametrised, 2-way set-associative, write-back, write-allocate data cache for the MEM stage.
- Successor to the direct-mapped read-only data cache; adds stores (word and byte), dirty-line write-back, LRU replacement, and configurable line and set counts.
- Sits between the pipeline (address, read/write enables, store data, stall) and the line-wide memory interface (read/write request, MemReady handshake).

Parameters:
- WORD_SIZE, 32, data and address width in bits.
- LINE_WORDS, 4, words per line (power of 2, at least 2). Offset bits OB = log2(LINE_WORDS*WORD_SIZE/8).
- NUM_SETS, 4, number of sets (power of 2). Index bits IB = log2(NUM_SETS); tag = A[WORD_SIZE-1:OB+IB].

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: synchronous, active-high reset.
- A, input, WORD_SIZE: byte address. Word select = A[OB-1:2]; byte select = A[1:0].
- ReadEnable, input, 1: load request.
- WriteEnable, input, 1: store request.
- WriteByte, input, 1: when 1, store writes WData[7:0] to byte A[1:0]; when 0, stores the full word.
- WData, input, WORD_SIZE: store data.
- Value, output, WORD_SIZE: load data.
- CacheStall, output, 1: pipeline must hold A, enables and WData while high.
- AMem, output, WORD_SIZE: line-aligned memory address (low OB bits zero).
- MemRead, output, 1: line fill request.
- MemWrite, output, 1: line write-back request.
- MemWLine, output, LINE_WORDS*WORD_SIZE: victim line; word k at bits [k*WORD_SIZE +: WORD_SIZE].
- MemLine, input, LINE_WORDS*WORD_SIZE: fill line, same word packing as MemWLine.
- MemReady, input, 1: completes the current MemRead or MemWrite in the cycle it is high.

Behaviour:
- Storage per set: 2 ways, each with tag, valid, dirty and line data; 1 LRU bit per set (value = way to evict next).
- Reset: state IDLE; all valid, dirty and LRU bits 0; outputs MemRead=0, MemWrite=0, CacheStall=0, Value=0, AMem=0, MemWLine=0.
- Request = ReadEnable|WriteEnable. If both are high, the access is a store, and Value shows the pre-store word.
- Hit = valid & tag match in either way; at most one way may match.
- IDLE, hit:
  - CacheStall=0 combinationally.
  - Load: Value = selected word combinationally in the same cycle.
  - Store: word or byte updated at the clock edge; dirty set.
  - Any hit sets LRU to the other way.
- IDLE, miss:
  - CacheStall=1 combinationally in the same cycle.
  - Victim choice: first invalid way, way0 before way1; if both ways are valid, the LRU way.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - MemWrite=1; AMem = {victim tag, index, OB zeros}; MemWLine = victim data; CacheStall=1.
  - On MemReady: clear victim dirty, go to REFILL.
- REFILL:
  - MemRead=1; AMem = {A tag, index, OB zeros}; CacheStall=1.
  - On MemReady: install MemLine, tag, valid=1, dirty=0 in the victim way; go to IDLE.
- After a fill, the access re-evaluates in IDLE as a hit. CacheStall falls in the cycle after MemReady.
- Minimum miss penalty: clean miss = 2 stall cycles with zero-wait memory; dirty miss = 3.
- MemRead and MemWrite are never high together. Both are held stable until MemReady.
- MemReady in IDLE is ignored.
- Request inputs are ignored while not in IDLE; the pipeline holds them stable.
- No request in IDLE: no state change, CacheStall=0, Value holds its last value.
- rst in any state (including mid-WRITEBACK/REFILL): next cycle IDLE with all lines invalid; the in-flight transfer is abandoned and MemRead/MemWrite drop.
- Byte store uses little-endian lanes: byte b occupies bits [8b+7:8b].

Test Plan:
- Defaults throughout (OB=4, IB=2, tag = A[31:6]). MemLine words w3..w0 = 0x33333333, 0x22222222, 0x11111111, 0x00000000.
- Cold load, A=0x104: CacheStall=1; MemRead=1 with AMem=0x100. MemReady with the line above -> next cycle CacheStall=0, Value=0x11111111, MemWrite never asserted.
- Store hit after the previous test: WriteEnable, WriteByte=1, A=0x106, WData=0xAB -> no stall. A load of 0x104 then returns 0x11AB1111.
- Conflict set 0: load 0x000, load 0x040, load 0x000, then load 0x080 -> the line at 0x040 is evicted (clean, so no MemWrite). A load of 0x000 then hits with no stall.
- Dirty eviction: word store 0xDEADBEEF to 0x040; load 0x000; load 0x080 -> MemWrite=1, AMem=0x040, MemWLine word0=0xDEADBEEF. MemReady -> MemRead=1 with AMem=0x080. MemReady -> stall clears on the next cycle.
- Reset mid-refill: rst during REFILL -> next cycle MemRead=0, CacheStall=0. A load of the same address misses again.
- Idle bus: no enables for 10 cycles with MemReady toggling -> CacheStall, MemRead and MemWrite stay 0.
